// File: rtl/n64_joybus_tx_if.sv
// Request/status bundle between the response builder and the joybus transmitter.
// The builder holds the master side; the transmitter holds the slave side.
interface n64_joybus_tx_if;
   logic        start;
   logic [31:0] tx_data;
   logic [2:0]  tx_len;
   logic        line_low;
   logic        busy;
   logic        done;

   modport master (output start, tx_data, tx_len, input line_low, busy, done);
   modport slave  (input start, tx_data, tx_len, output line_low, busy, done);
endinterface

// File: rtl/n64_joybus_tx.sv
// N64 joybus response transmitter: pulse-width encodes up to 4 bytes MSB-first plus a stop bit.
// Define RESP_DELAY_EN to insert a RESP_DELAY_US turnaround before the first bit.
module n64_joybus_tx #(
   parameter int US_TICKS      = 12,
   parameter int RESP_DELAY_US = 2
) (
   input  logic           clk,
   input  logic           reset,
   n64_joybus_tx_if.slave bus
);

   localparam int CNT_W = $clog2(3 * US_TICKS);
   localparam logic [CNT_W-1:0] END_1US = CNT_W'(US_TICKS - 1);
   localparam logic [CNT_W-1:0] END_2US = CNT_W'(2 * US_TICKS - 1);
   localparam logic [CNT_W-1:0] END_3US = CNT_W'(3 * US_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
`ifdef RESP_DELAY_EN
      DELAY     = 3'd1,
`endif
      BIT_LOW   = 3'd2,
      BIT_HIGH  = 3'd3,
      STOP_LOW  = 3'd4,
      STOP_HIGH = 3'd5
   } state_t;

   state_t           state_reg, state_next;
   logic [31:0]      shift_reg;
   logic [5:0]       bits_left_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] phase_end;
   logic             phase_last;
   logic             accept;
   logic             line_low_reg, line_low_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic [2:0]       len_clamped;

`ifdef RESP_DELAY_EN
   localparam int DLY_CYCLES = RESP_DELAY_US * US_TICKS;
   localparam int DLY_W      = $clog2(DLY_CYCLES + 1);
   logic [DLY_W-1:0] dly_cnt_reg;
   logic             dly_last;
   assign dly_last = (dly_cnt_reg == DLY_W'(DLY_CYCLES - 1));
`endif

   assign len_clamped = (bus.tx_len > 3'd4) ? 3'd4 : bus.tx_len;

   // Low/high split of a bit cell depends on the bit currently at the MSB.
   always_comb begin
      phase_end = END_2US;
      case (state_reg)
         BIT_LOW:  phase_end = shift_reg[31] ? END_1US : END_3US;
         BIT_HIGH: phase_end = shift_reg[31] ? END_3US : END_1US;
         default:  phase_end = END_2US;
      endcase
      phase_last = (cnt_reg == phase_end);
   end

   // busy_reg set while still in IDLE marks the cycle right after acceptance.
   always_comb begin
      state_next = state_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (busy_reg) begin
`ifdef RESP_DELAY_EN
               state_next = DELAY;
`else
               state_next = BIT_LOW;
`endif
            end else if (bus.start && (bus.tx_len != 3'd0)) begin
               accept    = 1'b1;
               busy_next = 1'b1;
            end
         end
`ifdef RESP_DELAY_EN
         DELAY:     if (dly_last) state_next = BIT_LOW;
`endif
         BIT_LOW:   if (phase_last) state_next = BIT_HIGH;
         BIT_HIGH:  if (phase_last) state_next = (bits_left_reg == 6'd1) ? STOP_LOW : BIT_LOW;
         STOP_LOW:  if (phase_last) state_next = STOP_HIGH;
         STOP_HIGH: begin
            if (phase_last) begin
               state_next = IDLE;
               done_next  = 1'b1;
               busy_next  = 1'b0;
            end
         end
         default:   state_next = IDLE;
      endcase
      line_low_next = (state_next == BIT_LOW) || (state_next == STOP_LOW);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg     <= '0;
         bits_left_reg <= '0;
         cnt_reg       <= '0;
         line_low_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         line_low_reg <= line_low_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         if (accept) begin
            shift_reg     <= bus.tx_data;
            bits_left_reg <= {len_clamped, 3'b000};
         end else if ((state_reg == BIT_HIGH) && phase_last) begin
            shift_reg     <= {shift_reg[30:0], 1'b0};
            bits_left_reg <= bits_left_reg - 6'd1;
         end
         if ((state_next != state_reg) || (state_reg == IDLE))
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + 1'b1;
      end
   end

`ifdef RESP_DELAY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  dly_cnt_reg <= '0;
      else if (state_reg == DELAY) dly_cnt_reg <= dly_cnt_reg + 1'b1;
      else                        dly_cnt_reg <= '0;
   end
`endif

   assign bus.line_low = line_low_reg;
   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;

endmodule

// File: doc/n64_joybus_tx.md
Name: n64_joybus_tx

Overview:
- Transmits the adapter's controller response to the N64 console over the single-wire joybus line.
- Accepts a response word of up to 4 bytes, for example the poll response {buttons, C-buttons, stick X, stick Y} or the 3-byte info response.
- Serialises the word MSB-first using N64 pulse-width bit encoding, then appends a stop bit.
- Drives an open-drain enable only; the pad tristate is outside this block.

Parameters:
- US_TICKS, 12, clk cycles per microsecond (12 MHz system clock).
- RESP_DELAY_US, 2, turnaround delay in µs before the first bit. Used only with RESP_DELAY_EN.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to transmit; sampled only in IDLE.
- tx_data  input  32  response bytes; [31:24] is sent first, each byte MSB-first.
- tx_len  input  3  number of bytes to send, 1..4. Value 0 means no request; values 5..7 are clamped to 4.
- line_low  output  1  1 = pull the joybus line low, 0 = release it (pulled up externally).
- busy  output  1  high from request acceptance until done.
- done  output  1  one-cycle pulse when the frame and guard time are complete.

Behaviour:
- Reset (async): line_low=0, busy=0, done=0, state=IDLE, all counters 0. Reset mid-frame releases the line immediately; the frame is abandoned and never resumed.
- Acceptance: in IDLE, start=1 with tx_len!=0 latches tx_data and the clamped length (bits = 8*len) and sets busy on the next edge.
  - start with tx_len=0 is ignored: no busy, no done.
  - start while busy is ignored; tx_data/tx_len changes during a frame have no effect.
- States: IDLE -> [DELAY] -> BIT_LOW -> BIT_HIGH -> (next bit: BIT_LOW | last bit: STOP_LOW) -> STOP_HIGH -> IDLE.
- Timing is counted with a tick counter in whole µs (US_TICKS cycles each).
- BIT_LOW: line_low=1. Duration is 1 µs for a '1' bit and 3 µs for a '0' bit.
- BIT_HIGH: line_low=0. Duration is 3 µs for a '1' bit and 1 µs for a '0' bit.
  - Every bit is exactly 4*US_TICKS cycles.
  - The shift register shifts left at the end of BIT_HIGH; the bit counter decrements there.
- STOP_LOW: line_low=1 for 2 µs. STOP_HIGH: line_low=0 for 2 µs of guard time.
- On leaving STOP_HIGH: done=1 for one cycle, busy=0 in the same cycle, state returns to IDLE.
  - A new start is accepted the cycle after done.
- Latency without delay: start sampled at edge N gives line_low=1 from edge N+1.
- Frame length from the first line_low rise to the done pulse:
  - (bits*4 + 4)*US_TICKS cycles.
  - 4 bytes at 12 MHz: 1584 cycles; 3 bytes: 1200 cycles.
- line_low, busy and done are registered outputs (no combinational paths from inputs).
- Counters are sized for 3*US_TICKS and for 32 bits; none wraps during a frame.

Optional Feature:
- Macro: RESP_DELAY_EN.
- When defined, the DELAY state is inserted after acceptance. line_low=0 and busy=1 for RESP_DELAY_US*US_TICKS cycles, then BIT_LOW begins. Reset during DELAY returns to IDLE.
- When undefined, the DELAY state and its counter are not compiled, and the first bit starts the cycle after acceptance.

Test Plan:
- Reset: assert reset mid-simulation asynchronously -> line_low=0, busy=0, done=0 without waiting for a clk edge.
- Poll frame: tx_len=4, tx_data=0x8000_0000, start -> the line follows this sequence:
  - first bit: low 12 cycles, high 36 cycles;
  - remaining 31 bits: low 36 cycles, high 12 cycles each;
  - stop: low 24 cycles, high 24 cycles;
  - done pulses exactly 1584 cycles after line_low first rises, and busy drops with it.
- Info frame: tx_len=3, tx_data=0x0500_02FF -> 24 bits decode as 0x05,0x00,0x02, the 0xFF byte is never sent, and done comes 1200 cycles after the first line_low rise.
- Illegal requests:
  - tx_len=0 with start -> busy stays 0 and no done.
  - tx_len=6 -> 32 bits are sent.
  - start pulsed at bit 5 of a running frame -> ignored, only one done.
- Reset mid-frame: reset during bit 10 -> line_low=0 immediately and busy=0. After release, start with 0xA5A5_A5A5, tx_len=4 -> a full correct frame is sent.
- Delay option: with RESP_DELAY_EN and RESP_DELAY_US=2 -> the first line_low rise is 25 cycles after the start edge (24 delay + 1), busy is high throughout, and the bit timing is unchanged.
